// File: rtl/stride_seq_if.sv
// stride_seq_if: valid/ready value channel from a sequence producer to the checker
//   valid  producer -> checker  a value is offered
//   value  producer -> checker  WIDTH-bit sequence value
//   ready  checker  -> producer checker accepts a value this cycle
interface stride_seq_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic [WIDTH-1:0] value;
    logic             ready;
    modport master (output valid, value, input ready);
    modport slave  (input valid, value, output ready);
endinterface

// File: rtl/stride_seq_checker.sv
// stride_seq_checker: checks a received START, START+STEP, ... (< LIMIT) sequence and reports pass/fail
//   clk, rst        clock and asynchronous active-high reset
//   start           one-cycle pulse that begins or restarts a run
//   in_if           slave side of the valid/ready value channel
//   err             one-cycle pulse on a mismatching beat
//   exp_value       next expected value (WIDTH+1 bits), loop-exit value after the run
//   sample_count    accepted beats this run, saturating
//   err_count       mismatches this run, saturating
//   done            run complete, held until the next start
//   pass            done with no mismatch and no timeout
//   timeout         run ended by the idle watchdog
// Optional watchdog enabled by defining STRIDE_CHK_TIMEOUT_EN.
module stride_seq_checker #(
    parameter int WIDTH   = 4,
    parameter int START   = 2,
    parameter int STEP    = 2,
    parameter int LIMIT   = 14,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    stride_seq_if.slave      in_if,
    output logic             err,
    output logic [WIDTH:0]   exp_value,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic             done,
    output logic             pass,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    localparam logic [WIDTH:0] ST    = (WIDTH+1)'(START);
    localparam logic [WIDTH:0] SP    = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] LIM   = (WIDTH+1)'(LIMIT);
    localparam bit             EMPTY = START >= LIMIT;

    state_t         state, state_nxt;
    logic           acc, mis, wd_hit;
    logic [WIDTH:0] exp_nxt;

    assign in_if.ready = state == CHECK;
    assign acc         = in_if.ready && in_if.valid;
    assign mis         = in_if.value != exp_value[WIDTH-1:0];
    // The extra top bit keeps the end test correct when the sum overflows WIDTH.
    assign exp_nxt     = exp_value + SP;
    assign done        = state == DONE;
    assign pass        = done && err_count == '0 && !timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = EMPTY ? DONE : CHECK;
        else if ((acc && exp_nxt >= LIM) || wd_hit)
            state_nxt = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err          <= 1'b0;
            exp_value    <= '0;
            sample_count <= '0;
            err_count    <= '0;
        end else if (start) begin
            err          <= 1'b0;
            exp_value    <= ST;
            sample_count <= '0;
            err_count    <= '0;
        end else if (acc) begin
            err          <= mis;
            exp_value    <= exp_nxt;
            sample_count <= sample_count + CNT_W'(~&sample_count);
            err_count    <= err_count + CNT_W'(mis && ~&err_count);
        end else begin
            err          <= 1'b0;
        end
    end

`ifdef STRIDE_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;

    // Fires on the idle CHECK cycle that brings the idle count up to TIMEOUT.
    assign wd_hit = in_if.ready && !acc && wd == WD_W'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (start) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (in_if.ready) begin
            wd      <= acc ? '0 : wd + 1'b1;
            if (wd_hit) timeout <= 1'b1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_stride_seq_checker.sv
// tb_stride_seq_checker: randomized self-checking bench against a sequence-index model
module tb_stride_seq_checker;
    localparam int W = 4, START = 2, STEP = 2, LIMIT = 14, TO = 16;

    logic clk = 0, rst = 1, start = 0, start2 = 0;
    int   tests = 0, fails = 0, cyc = 0, err_seen = 0;
    bit   ready2_seen = 0;

    stride_seq_if #(.WIDTH(W)) bus ();
    stride_seq_if #(.WIDTH(W)) bus2 ();

    logic         err, done, pass, tmo, err2, done2, pass2, tmo2;
    logic [W:0]   exp_value, exp_value2;
    logic [7:0]   sc, ec, sc2, ec2;

    stride_seq_checker #(.WIDTH(W), .START(START), .STEP(STEP), .LIMIT(LIMIT), .CNT_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .in_if(bus.slave), .err(err), .exp_value(exp_value),
        .sample_count(sc), .err_count(ec), .done(done), .pass(pass), .timeout(tmo));

    stride_seq_checker #(.WIDTH(W), .START(14), .STEP(STEP), .LIMIT(LIMIT), .CNT_W(8), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_if(bus2.slave), .err(err2), .exp_value(exp_value2),
        .sample_count(sc2), .err_count(ec2), .done(done2), .pass(pass2), .timeout(tmo2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Model: a run is the list of values START + k*STEP below LIMIT; state is just
    // how many of them have been accepted, mismatches seen, and watchdog status.
    int  n_seq, m_k, m_errs, m_idle;
    bit  m_on, m_err, m_to, m_r;

    function automatic bit m_ready();
        return m_on && m_k < n_seq && !m_to;
    endfunction
    function automatic bit m_done();
        return m_on && (m_k == n_seq || m_to);
    endfunction
    function automatic int sat(input int x);
        return x > 255 ? 255 : x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on = 0; m_k = 0; m_errs = 0; m_err = 0; m_to = 0; m_idle = 0;
        end else if (start) begin
            m_on = 1; m_k = 0; m_errs = 0; m_err = 0; m_to = 0; m_idle = 0;
        end else begin
            m_r   = m_ready();
            m_err = 0;
            if (m_r && bus.valid) begin
                m_err  = bus.value != 4'(START + m_k * STEP);
                m_errs += int'(m_err);
                m_k++;
                m_idle = 0;
            end else if (m_r) begin
                m_idle++;
`ifdef STRIDE_CHK_TIMEOUT_EN
                if (m_idle == TO) m_to = 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", int'(bus.ready), int'(m_ready()));
        check("err", int'(err), int'(m_err));
        check("exp_value", int'(exp_value), m_on ? START + m_k * STEP : 0);
        check("sample_count", int'(sc), sat(m_k));
        check("err_count", int'(ec), sat(m_errs));
        check("done", int'(done), int'(m_done()));
        check("pass", int'(pass), int'(m_done() && m_errs == 0 && !m_to));
        check("timeout", int'(tmo), int'(m_to));
        if (err) err_seen++;
        if (bus2.ready) ready2_seen = 1;
    end

    // All tasks assume they are entered 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input int v, input int maxgap);
        bit a;
        repeat ($urandom_range(maxgap, 0)) begin
            bus.valid = 0; bus.value = 4'($urandom);
            @(posedge clk); #1;
        end
        bus.valid = 1; bus.value = 4'(v);
        for (int i = 0; i < 50; i++) begin
            a = bus.ready;
            @(posedge clk); #1;
            if (a) return;
        end
        check("accept_wait", 0, 1);
    endtask

    task automatic full_run(input int maxgap);
        pulse_start();
        for (int v = START; v < LIMIT; v += STEP) send(v, maxgap);
        bus.valid = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, int'(bus.ready), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_exp"}, int'(exp_value), 0);
        check({tag, "_sc"}, int'(sc), 0);
        check({tag, "_ec"}, int'(ec), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_tmo"}, int'(tmo), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int c0, n;
        n_seq = 0;
        for (int v = START; v < LIMIT; v += STEP) n_seq++;
        bus.valid = 0; bus.value = 0;
        bus2.valid = 1; bus2.value = 4'd14;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        check("n_seq", n_seq, 6);
        rst = 0;
        @(posedge clk); #1;

        // Correct back-to-back run
        pulse_start();
        c0 = cyc;
        for (int v = 2; v <= 12; v += 2) send(v, 0);
        bus.valid = 0;
        check("t1_cycles", cyc - c0, 6);
        check("t1_done", int'(done), 1);
        check("t1_pass", int'(pass), 1);
        check("t1_sc", int'(sc), 6);
        check("t1_ec", int'(ec), 0);
        check("t1_exp", int'(exp_value), 14);

        // One wrong value
        err_seen = 0;
        pulse_start();
        send(2, 0); send(4, 0); send(7, 0);
        check("t2_err_pulse", int'(err), 1);
        send(8, 0);
        check("t2_err_clear", int'(err), 0);
        send(10, 0); send(12, 0);
        bus.valid = 0;
        @(posedge clk); #1;
        check("t2_err_seen", err_seen, 1);
        check("t2_ec", int'(ec), 1);
        check("t2_done", int'(done), 1);
        check("t2_pass", int'(pass), 0);

        // Random gaps; a beat held during start must not be counted
        for (int r = 0; r < 4; r++) begin
            bus.valid = 1; bus.value = 4'd5;
            pulse_start();
            for (int v = START; v < LIMIT; v += STEP) send(v, 3);
            bus.valid = 0;
            check("t3_done", int'(done), 1);
            check("t3_sc", int'(sc), 6);
            check("t3_pass", int'(pass), 1);
        end

        // Zero-sample run on the START=14 instance
        check("t4_done_before", int'(done2), 0);
        start2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        check("t4_done", int'(done2), 1);
        check("t4_pass", int'(pass2), 1);
        check("t4_sc", int'(sc2), 0);
        check("t4_exp", int'(exp_value2), 14);

        // Reset mid-run after 3 beats
        pulse_start();
        send(2, 0); send(4, 0); send(6, 0);
        bus.valid = 0;
        rst = 1;
        #1;
        check_zero("t5");
        @(posedge clk); #1;
        rst = 0;
        check("t5_done2", int'(done2), 0);
        full_run(0);
        check("t5_pass", int'(pass), 1);
        check("t5_sc", int'(sc), 6);

        // Idle behaviour in CHECK
        pulse_start();
        send(2, 0); send(4, 0);
        bus.valid = 0;
`ifdef STRIDE_CHK_TIMEOUT_EN
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_cycles", n, 16);
        check("t6_tmo", int'(tmo), 1);
        check("t6_done", int'(done), 1);
        check("t6_pass", int'(pass), 0);
        check("t6_sc", int'(sc), 2);
`else
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_idle_cycles", n, 40);
        check("t6_done", int'(done), 0);
        check("t6_tmo", int'(tmo), 0);
        check("t6_ready", int'(bus.ready), 1);
        for (int v = 6; v <= 12; v += 2) send(v, 0);
        bus.valid = 0;
        check("t6_pass", int'(pass), 1);
`endif

        // Random runs with random errors and mid-run restarts
        for (int r = 0; r < 20; r++) begin
            int nb;
            nb = $urandom_range(n_seq, 0);
            pulse_start();
            for (int k = 0; k < nb; k++)
                send(START + k * STEP ^ ($urandom_range(3, 0) == 0 ? $urandom_range(15, 1) : 0), 3);
            bus.valid = 0;
            @(posedge clk); #1;
        end

        check("t4_ready_never", int'(ready2_seen), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stride_seq_checker.md
# stride_seq_checker

Receive-side checker for stepped counter sequences. A producer emits START, START+STEP, … while the value stays below LIMIT; this block accepts those values over a valid/ready handshake and compares each one against an internally generated expected value. It counts samples and mismatches and reports pass/fail at end of run. It sits on the consumer side of any stimulus generator driving a stepped counter.

## Interface
- WIDTH, 4: width of sequence values.
- START, 2: first expected value.
- STEP, 2: increment between values; must be nonzero.
- LIMIT, 14: exclusive end; the run covers values v with v < LIMIT.
- CNT_W, 8: width of sample and error counters.
- TIMEOUT, 16: idle-cycle limit; used only with STRIDE_CHK_TIMEOUT_EN.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a run.
- in_valid  in  1  producer has a value.
- in_value  in  WIDTH  sequence value.
- in_ready  out  1  checker accepts a value this cycle.
- err  out  1  one-cycle pulse on a mismatch.
- exp_value  out  WIDTH+1  next expected value; after the run, the loop-exit value.
- sample_count  out  CNT_W  values accepted this run; saturating.
- err_count  out  CNT_W  mismatches this run; saturating.
- done  out  1  run complete; held until the next start.
- pass  out  1  done and err_count == 0 and no timeout.
- timeout  out  1  run ended by the watchdog; held until the next start.

## Operation
- States are IDLE, CHECK and DONE.
- Reset value of every output is 0. The state resets to IDLE.
- IDLE: in_ready=0. On start:
  - clear both counters, err, done and timeout;
  - load exp_value with START;
  - go to CHECK, or go to DONE if START >= LIMIT (zero-sample run).
- CHECK: in_ready=1. A beat is accepted when in_valid && in_ready at a rising edge. On each accepted beat:
  - sample_count increments;
  - if in_value != exp_value[WIDTH-1:0], err pulses and err_count increments;
  - exp_value becomes exp_value + STEP, computed at WIDTH+1 bits.
  - If the new exp_value >= LIMIT, go to DONE.
- DONE: in_ready=0, done=1, and pass = (err_count == 0) && !timeout. Stays until start.
- start in CHECK or DONE restarts the run exactly as from IDLE. A beat offered in the same cycle as start is not counted.
- Counters saturate at 2^CNT_W − 1 and do not wrap.
- Arithmetic: the extra bit in exp_value stops the end test being defeated by WIDTH overflow. With the defaults, exp_value runs 2, 4, …, 12, ends at 14, and 6 samples are accepted.
- An rst assertion mid-run aborts immediately to IDLE with all outputs 0. No partial result is retained.

## Timing
- in_ready is decoded from the state register, with no combinational path from in_valid.
- err and both counters update on the edge that accepts the beat, visible the following cycle.
- done rises the cycle after the final accepted beat.
- For a zero-sample run, done rises the cycle after start.
- Throughput is one beat per cycle with no bubbles. Back-to-back valid beats are all accepted.
- start to first possible acceptance: 1 cycle, since in_ready goes high the cycle after start.

## Configuration
- STRIDE_CHK_TIMEOUT_EN defined:
  - a watchdog counts consecutive CHECK cycles with no accepted beat, and resets on every acceptance;
  - when it reaches TIMEOUT, the block enters DONE with timeout=1 and pass=0.
- STRIDE_CHK_TIMEOUT_EN undefined:
  - no watchdog logic;
  - timeout is tied to 0, and CHECK waits indefinitely.
- Port list is identical in both builds.

## Test plan
- Defaults: start, then 2, 4, 6, 8, 10, 12, one per cycle. Required: done=1, pass=1, sample_count=6, err_count=0, exp_value=14.
- Defaults: send 2, 4, 7, 8, 10, 12. Required: one err pulse on the beat after 7 is accepted, err_count=1, done=1, pass=0.
- Random in_valid gaps with the correct sequence. Required: acceptance only when in_ready=1, sample_count=6, pass=1. The done cycle is one after the last acceptance.
- START=14: pulse start. Required: done=1 the next cycle, sample_count=0, pass=1, in_ready never asserted.
- Reset mid-run after 3 beats. Required: all outputs 0 immediately. A fresh start then gives a clean pass.
- With STRIDE_CHK_TIMEOUT_EN and TIMEOUT=16: send 2, 4, then idle. Required: timeout=1, done=1, pass=0, sample_count=2, 16 cycles after the last acceptance.
